divider_cal: RTL
================

// Module: divider_cal
// PURPOSE
//  Sequential signed 16-bit divider; the inverse operation of the radix-16 multiplier datapath.
//  Takes a dividend and divisor, runs a radix-2 restoring division on their magnitudes (one
//  quotient bit per cycle), then applies sign correction. Uses the same IDLE/EXEC/OUT/DONE
//  control flow as the multiplier, and returns {remainder, quotient} on a 32-bit result bus.
// PARAMETERS
//  WIDTH  16  operand width; quotient/remainder are WIDTH bits, result is 2*WIDTH
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-high reset
//  op_start    in   1   start request; sampled only in IDLE
//  op_clear    in   1   synchronous abort/clear, any state
//  dividend    in   16  signed two's-complement dividend, captured at start
//  divisor     in   16  signed two's-complement divisor, captured at start
//  state       out  2   00 IDLE, 01 EXEC, 10 OUT, 11 DONE
//  op_done     out  1   high while in DONE
//  result      out  32  {remainder[15:0], quotient[15:0]}
//  div_zero    out  1   divisor was 0 for the current/last operation
//  ovf         out  1   -32768 / -1 (quotient does not fit)
// BEHAVIOUR
//  Reset (and op_clear): state=IDLE; result, op_done, div_zero, ovf, count and internal regs = 0.
//   op_clear wins over op_start and over every state transition in the same cycle.
//  IDLE: if op_start, capture sign bits and magnitudes |dividend|, |divisor| (17-bit safe, so
//   |-32768| = 32768 is exact); clear div_zero/ovf.
//   - divisor==0 -> go to OUT directly, set div_zero.
//   - otherwise go to EXEC, count=0, partial remainder=0.
//  EXEC: each cycle, shift remainder left by one and bring in the next dividend MSB. Trial-subtract
//   |divisor|. If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
//   count increments. After exactly WIDTH EXEC cycles (count==WIDTH-1 on the last one) -> OUT.
//   op_start ignored.
//  OUT (1 cycle): write result; -> DONE.
//   - normal: quotient negated if sign(dividend)^sign(divisor); remainder negated if dividend < 0.
//     Division truncates toward zero, and the remainder takes the dividend's sign.
//   - div_zero: quotient=16'hFFFF, remainder=dividend.
//   - dividend=16'h8000, divisor=16'hFFFF: quotient=16'h8000 (wrap), remainder=0, ovf=1.
//  DONE: op_done=1; result/flags held; op_start ignored; stay until op_clear -> IDLE
//   (result cleared). No other exit from DONE.
//  result changes only in OUT or on reset/op_clear; it is stable during IDLE/EXEC.
//  Latency: op_start sampled at edge 0 -> EXEC cycles 1..16 -> OUT cycle 17 -> op_done=1 from
//   cycle 18. For a zero divisor: OUT cycle 1, op_done from cycle 2.
//  Operand inputs are don't-care after capture; changes mid-operation have no effect.
//  All arithmetic is two's-complement mod 2^16 for outputs; internal remainder is 17 bits.
// TESTING
//  100 / 7 -> result={16'h0002,16'h000E}, op_done rises exactly 18 cycles after op_start.
//  -100 / 7 -> quotient 16'hFFF2 (-14), remainder 16'hFFFE (-2); 100 / -7 -> q -14, r +2.
//  5 / 0 -> div_zero=1, result={16'h0005,16'hFFFF}, op_done 2 cycles after start, EXEC skipped.
//  -32768 / -1 -> ovf=1, result={16'h0000,16'h8000}; -32768 / 1 -> q 16'h8000, ovf=0.
//  op_clear asserted in EXEC cycle 8 together with op_start -> next cycle IDLE, result=0,
//   op_done=0; a fresh start then completes normally.
//  reset mid-EXEC -> all outputs 0 next cycle; op_start pulses during EXEC/DONE leave
//   state and result unchanged.

Source files
------------

// File: rtl/divider_cal.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// followed by sign correction. Returns {remainder, quotient}.
module divider_cal #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [1:0]         state,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_OUT  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH:0]     dvr_q, dvr_d;
  logic               sdd_q, sdd_d;
  logic               sdv_q, sdv_d;
  logic               ovf_p_q, ovf_p_d;
  logic               op_done_q, op_done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               div_zero_q, div_zero_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH-1:0]   dvr_mag_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_out_s;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvr_d      = dvr_q;
    sdd_d      = sdd_q;
    sdv_d      = sdv_q;
    ovf_p_d    = ovf_p_q;
    op_done_d  = op_done_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;

    // dvd_q holds the dividend magnitude, which shifts out MSB-first while quotient bits shift in
    rem_sh_s  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    dvr_mag_s = divisor[WIDTH-1] ? (ZERO - divisor) : divisor;
    quo_s     = (sdd_q ^ sdv_q) ? (ZERO - dvd_q) : dvd_q;
    rem_out_s = sdd_q ? (ZERO - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        if (op_start) begin
          sdd_d      = dividend[WIDTH-1];
          sdv_d      = divisor[WIDTH-1];
          dvd_d      = dividend[WIDTH-1] ? (ZERO - dividend) : dividend;
          dvr_d      = {1'b0, dvr_mag_s};
          ovf_p_d    = (dividend == MIN_VAL) && (divisor == {WIDTH{1'b1}});
          ovf_d      = 1'b0;
          count_d    = {CW{1'b0}};
          rem_d      = {(WIDTH+1){1'b0}};
          div_zero_d = (divisor == ZERO);
          state_d    = (divisor == ZERO) ? S_OUT : S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (rem_sh_s >= dvr_q) begin
          rem_d = rem_sh_s - dvr_q;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh_s;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        state_d = (count_q == CW'(WIDTH-1)) ? S_OUT : S_EXEC;
      end
      S_OUT: begin
        // With a zero divisor EXEC was skipped, so dvd_q is still the untouched magnitude
        if (div_zero_q) begin
          result_d = {(sdd_q ? (ZERO - dvd_q) : dvd_q), {WIDTH{1'b1}}};
        end else begin
          result_d = {rem_out_s, quo_s};
        end
        ovf_d     = ovf_p_q;
        op_done_d = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (op_clear) begin
      state_d    = S_IDLE;
      count_d    = {CW{1'b0}};
      rem_d      = {(WIDTH+1){1'b0}};
      dvd_d      = ZERO;
      dvr_d      = {(WIDTH+1){1'b0}};
      sdd_d      = 1'b0;
      sdv_d      = 1'b0;
      ovf_p_d    = 1'b0;
      op_done_d  = 1'b0;
      result_d   = {(2*WIDTH){1'b0}};
      div_zero_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      ovf_p_d = ovf_p_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= {CW{1'b0}};
      rem_q      <= {(WIDTH+1){1'b0}};
      dvd_q      <= ZERO;
      dvr_q      <= {(WIDTH+1){1'b0}};
      sdd_q      <= 1'b0;
      sdv_q      <= 1'b0;
      ovf_p_q    <= 1'b0;
      op_done_q  <= 1'b0;
      result_q   <= {(2*WIDTH){1'b0}};
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvr_q      <= dvr_d;
      sdd_q      <= sdd_d;
      sdv_q      <= sdv_d;
      ovf_p_q    <= ovf_p_d;
      op_done_q  <= op_done_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign state    = state_q;
  assign op_done  = op_done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;

endmodule
